// File: rtl/sc_lsu.sv
// rtl/sc_lsu.sv - load/store unit with sub-word extract and read-modify-write stores
module sc_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          req,
    input  logic          st,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          fault,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          mem_we
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state;
    logic          a_st;
    logic [1:0]    a_size;
    logic          a_uns;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;

    logic          bad;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;
    logic [DW-1:0] ld_val;
    logic [DW-1:0] st_word;

    always_comb begin
        bad = 1'b0;
        case (size)
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
    end

    // Lanes are little-endian: byte k lives at bits [8k+7:8k].
    always_comb begin
        ld_b    = mem_dout[{a_addr[1:0], 3'b000} +: 8];
        ld_h    = a_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
        ld_val  = mem_dout;
        st_word = mem_dout;
        case (a_size)
            2'b00: begin
                ld_val = a_uns ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
                st_word[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
            end
            2'b01: begin
                ld_val = a_uns ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
                st_word[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
            end
            default: begin
                ld_val  = mem_dout;
                st_word = a_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            mem_we   <= 1'b0;
            rdata    <= '0;
            mem_din  <= '0;
            mem_addr <= '0;
            a_st     <= 1'b0;
            a_size   <= 2'b00;
            a_uns    <= 1'b0;
            a_addr   <= '0;
            a_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        a_st    <= st;
                        a_size  <= size;
                        a_uns   <= uns;
                        a_addr  <= addr;
                        a_wdata <= wdata;
                        fault   <= bad;
                        busy    <= 1'b1;
                        if (bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (st && size == 2'b10) begin
                            state    <= WR;
                            mem_we   <= 1'b1;
                            mem_din  <= wdata;
                            mem_addr <= {addr[AW-1:2], 2'b00};
                        end else begin
                            state    <= RD;
                            mem_addr <= {addr[AW-1:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    // Sub-word stores merge into the old word; loads finish here.
                    if (a_st) begin
                        state   <= WR;
                        mem_we  <= 1'b1;
                        mem_din <= st_word;
                    end else begin
                        state    <= DONE;
                        done     <= 1'b1;
                        rdata    <= ld_val;
                        mem_addr <= '0;
                    end
                end
                WR: begin
                    state    <= DONE;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                    done     <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
